// File: rtl/mips_mem_responder.sv
// Word-addressed memory responder for the MIPS32 core: round-robin arbitration between
// fetch and data ports, one outstanding transaction, WAIT_CYCLES (0..15) extra latency.
module mips_mem_responder #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [31:0] if_req_addr,
  output logic        if_rsp_valid,
  input  logic        if_rsp_ready,
  output logic [31:0] if_rsp_data,
  output logic        if_rsp_err,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic        d_req_we,
  input  logic [31:0] d_req_addr,
  input  logic [31:0] d_req_wdata,
  output logic        d_rsp_valid,
  input  logic        d_rsp_ready,
  output logic [31:0] d_rsp_rdata,
  output logic        d_rsp_err,
  output logic        busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  typedef enum logic {PORT_FETCH, PORT_DATA} port_t;

  state_t        state, state_nx;
  port_t         last_grant, port_q;
  logic          we_q;
  logic [31:0]   addr_q, wdata_q;
  logic [3:0]    wait_cnt;
  logic [31:0]   rsp_data_q;
  logic          rsp_err_q;
  logic          grant_fetch, grant_data, accept, access, rsp_done, in_range;
  logic [AW-1:0] mem_idx;

  logic [31:0]   mem [DEPTH];

  // Arbitration: a lone valid wins; on a tie the port not served last time wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    grant_data  = 1'b0;
    grant_fetch = 1'b0;
    if (state == S_IDLE) begin
      grant_data  = d_req_valid && (!if_req_valid || last_grant == PORT_FETCH);
      grant_fetch = if_req_valid && !grant_data;
    end
  end

  assign accept   = grant_fetch || grant_data;
  // wait_cnt holds the wait cycles still to burn; the edge seeing 0 is the access edge.
  assign access   = (state == S_WAIT) && (wait_cnt == 4'd0);
  assign rsp_done = (state == S_RESP) &&
                    ((port_q == PORT_FETCH) ? if_rsp_ready : d_rsp_ready);
  assign in_range = (addr_q < 32'(DEPTH));
  assign mem_idx  = addr_q[AW-1:0];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (accept)   state_nx = S_WAIT;
      S_WAIT:  if (access)   state_nx = S_RESP;
      S_RESP:  if (rsp_done) state_nx = S_IDLE;
      default:               state_nx = S_IDLE;
    endcase
  end

  // Output logic; the non-selected port's response outputs stay 0.
  always_comb begin
    if_req_ready = grant_fetch;
    d_req_ready  = grant_data;
    busy         = (state != S_IDLE);
    if_rsp_valid = (state == S_RESP) && (port_q == PORT_FETCH);
    d_rsp_valid  = (state == S_RESP) && (port_q == PORT_DATA);
    if_rsp_data  = if_rsp_valid ? rsp_data_q : 32'd0;
    if_rsp_err   = if_rsp_valid && rsp_err_q;
    d_rsp_rdata  = d_rsp_valid ? rsp_data_q : 32'd0;
    d_rsp_err    = d_rsp_valid && rsp_err_q;
  end

  // Request capture, wait counter and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= PORT_FETCH;
      port_q     <= PORT_FETCH;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wait_cnt   <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      if (accept) begin
        port_q     <= grant_data ? PORT_DATA : PORT_FETCH;
        last_grant <= grant_data ? PORT_DATA : PORT_FETCH;
        we_q       <= grant_data && d_req_we;
        addr_q     <= grant_data ? d_req_addr : if_req_addr;
        wdata_q    <= grant_data ? d_req_wdata : 32'd0;
        wait_cnt   <= 4'(WAIT_CYCLES);
      end
      if (state == S_WAIT && !access) wait_cnt <= wait_cnt - 4'd1;
      if (access) begin
        rsp_err_q  <= !in_range;
        rsp_data_q <= (in_range && !we_q) ? mem[mem_idx] : 32'd0;
      end
      if (rsp_done) begin
        rsp_data_q <= '0;
        rsp_err_q  <= 1'b0;
      end
    end
  end

  // NOTE: the memory array has no reset; contents survive rst_n and map onto plain RAM.
  always_ff @(posedge clk) begin
    if (access && in_range && we_q) mem[mem_idx] <= wdata_q;
  end

endmodule

// File: tb/tb_mips_mem_responder.sv
// Directed bench for mips_mem_responder: data-port vector table plus arbitration,
// backpressure, zero-wait-state and mid-transaction reset sequences.
module tb_mips_mem_responder;

  logic        clk, rst_n;
  logic        if_req_valid, if_req_ready, if_rsp_valid, if_rsp_ready, if_rsp_err;
  logic [31:0] if_req_addr, if_rsp_data;
  logic        d_req_valid, d_req_ready, d_req_we, d_rsp_valid, d_rsp_ready, d_rsp_err, busy;
  logic [31:0] d_req_addr, d_req_wdata, d_rsp_rdata;

  // Zero-wait-state instance, fetch port only
  logic        if_req_valid_0, if_req_ready_0, if_rsp_valid_0, if_rsp_ready_0, if_rsp_err_0;
  logic [31:0] if_req_addr_0, if_rsp_data_0;
  logic        d_req_ready_0, d_rsp_valid_0, d_rsp_err_0, busy_0;
  logic [31:0] d_rsp_rdata_0;

  int tests = 0;
  int fails = 0;

  mips_mem_responder #(.DEPTH(1024), .WAIT_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_ready(if_rsp_ready), .if_rsp_data(if_rsp_data),
    .if_rsp_err(if_rsp_err),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
    .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
    .d_rsp_valid(d_rsp_valid), .d_rsp_ready(d_rsp_ready), .d_rsp_rdata(d_rsp_rdata),
    .d_rsp_err(d_rsp_err), .busy(busy)
  );

  mips_mem_responder #(.DEPTH(1024), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid_0), .if_req_ready(if_req_ready_0), .if_req_addr(if_req_addr_0),
    .if_rsp_valid(if_rsp_valid_0), .if_rsp_ready(if_rsp_ready_0), .if_rsp_data(if_rsp_data_0),
    .if_rsp_err(if_rsp_err_0),
    .d_req_valid(1'b0), .d_req_ready(d_req_ready_0), .d_req_we(1'b0),
    .d_req_addr(32'd0), .d_req_wdata(32'd0),
    .d_rsp_valid(d_rsp_valid_0), .d_rsp_ready(1'b1), .d_rsp_rdata(d_rsp_rdata_0),
    .d_rsp_err(d_rsp_err_0), .busy(busy_0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One data-port transaction with rsp_ready high; lat counts edges from accept to rsp_valid.
  task automatic d_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err, output int lat);
    int n;
    @(negedge clk);
    d_req_valid = 1'b1; d_req_we = we; d_req_addr = addr; d_req_wdata = wdata;
    d_rsp_ready = 1'b1;
    n = 0;
    #1;
    while (!d_req_ready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check("d_accept_timeout", 32'(n >= 20), 32'd0);
    @(posedge clk);
    @(negedge clk);
    d_req_valid = 1'b0; d_req_we = 1'b0; d_req_wdata = 32'd0;
    lat = 0;
    while (!d_rsp_valid && lat < 40) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    rdata = d_rsp_rdata;
    err   = d_rsp_err;
    @(posedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[14];

  initial begin
    logic [31:0] rdata;
    logic        err;
    int          lat;
    logic        grant_seq[4];
    int          acc_c[4];
    int          ng, last_acc, overlap, rsp_c;

    vecs[0]  = '{1'b1, 32'd5,          32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'd5,          32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'd2,          32'h12345678, 32'h0,        1'b0};
    vecs[3]  = '{1'b1, 32'd3,          32'h33330003, 32'h0,        1'b0};
    vecs[4]  = '{1'b1, 32'd7,          32'h77770007, 32'h0,        1'b0};
    vecs[5]  = '{1'b1, 32'd9,          32'h00000011, 32'h0,        1'b0};
    vecs[6]  = '{1'b0, 32'd1024,       32'h0,        32'h0,        1'b1};
    vecs[7]  = '{1'b0, 32'h80000002,   32'h0,        32'h0,        1'b1};
    vecs[8]  = '{1'b0, 32'd2,          32'h0,        32'h12345678, 1'b0};
    vecs[9]  = '{1'b1, 32'd1023,       32'hA5A5A5A5, 32'h0,        1'b0};
    vecs[10] = '{1'b0, 32'd1023,       32'h0,        32'hA5A5A5A5, 1'b0};
    vecs[11] = '{1'b1, 32'd0,          32'hCAFEF00D, 32'h0,        1'b0};
    vecs[12] = '{1'b1, 32'd1024,       32'hFFFFFFFF, 32'h0,        1'b1};
    vecs[13] = '{1'b0, 32'd0,          32'h0,        32'hCAFEF00D, 1'b0};

    rst_n = 1'b1;
    if_req_valid = 1'b0; if_req_addr = 32'd0; if_rsp_ready = 1'b0;
    d_req_valid = 1'b0; d_req_we = 1'b0; d_req_addr = 32'd0; d_req_wdata = 32'd0;
    d_rsp_ready = 1'b0;
    if_req_valid_0 = 1'b0; if_req_addr_0 = 32'd0; if_rsp_ready_0 = 1'b0;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check("reset_busy",         busy,         32'd0);
    check("reset_d_rsp_valid",  d_rsp_valid,  32'd0);
    check("reset_if_rsp_valid", if_rsp_valid, 32'd0);
    check("reset_d_rsp_rdata",  d_rsp_rdata,  32'd0);
    check("reset_if_rsp_data",  if_rsp_data,  32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Data-port vector table
    for (int i = 0; i < 14; i++) begin
      d_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, rdata, err, lat);
      check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d_err", i),   err,   32'(vecs[i].exp_err));
      check($sformatf("vec%0d_lat", i),   lat,   32'd2);
    end

    // Round-robin with both ports continuously valid; after reset a tie goes to DATA
    pulse_reset();
    if_req_valid = 1'b1; if_req_addr = 32'd3; if_rsp_ready = 1'b1;
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 32'd7; d_rsp_ready = 1'b1;
    ng = 0; last_acc = 0; overlap = 0;
    for (int c = 0; c < 80 && ng < 4; c++) begin
      #1;
      if (if_rsp_valid && d_rsp_valid) overlap++;
      if (if_rsp_valid) check("arb_if_rsp_data", if_rsp_data, 32'h33330003);
      if (d_rsp_valid)  check("arb_d_rsp_rdata", d_rsp_rdata, 32'h77770007);
      if (if_req_ready || d_req_ready) begin
        check("arb_single_ready", 32'(if_req_ready && d_req_ready), 32'd0);
        if (ng > 0) check("arb_spacing", c - last_acc, 32'd4);
        grant_seq[ng] = d_req_ready;
        last_acc = c;
        ng++;
      end
      @(negedge clk);
    end
    if_req_valid = 1'b0; d_req_valid = 1'b0;
    check("arb_grant_count", ng, 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < ng) check($sformatf("arb_grant%0d", k), 32'(grant_seq[k]), 32'((k % 2) == 0));
    end
    repeat (6) begin
      @(negedge clk);
      if (if_rsp_valid && d_rsp_valid) overlap++;
    end
    check("arb_rsp_overlap", overlap, 32'd0);
    check("arb_idle_after", busy, 32'd0);

    // Response backpressure with a competing fetch request held valid
    @(negedge clk);
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 32'd5; d_rsp_ready = 1'b0;
    #1;
    check("bp_accept_ready", d_req_ready, 32'd1);
    @(posedge clk);
    @(negedge clk);
    d_req_valid = 1'b0;
    if_req_valid = 1'b1; if_req_addr = 32'd3; if_rsp_ready = 1'b1;
    lat = 0;
    while (!d_rsp_valid && lat < 10) begin
      @(negedge clk); lat++;
    end
    for (int c = 0; c < 5; c++) begin
      check("bp_valid",      d_rsp_valid,  32'd1);
      check("bp_rdata",      d_rsp_rdata,  32'hDEADBEEF);
      check("bp_if_ready",   if_req_ready, 32'd0);
      check("bp_d_ready",    d_req_ready,  32'd0);
      check("bp_busy",       busy,         32'd1);
      @(negedge clk);
    end
    d_rsp_ready = 1'b1; if_req_valid = 1'b0;
    @(negedge clk);
    check("bp_release_busy",  busy,        32'd0);
    check("bp_release_valid", d_rsp_valid, 32'd0);
    check("bp_release_rdata", d_rsp_rdata, 32'd0);
    repeat (3) @(negedge clk);
    check("bp_no_fetch_rsp", if_rsp_valid, 32'd0);

    // Reset during WAIT of a store: outputs clear at once, store discarded
    @(negedge clk);
    d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 32'd9; d_req_wdata = 32'h99999999;
    #1;
    check("rst_store_ready", d_req_ready, 32'd1);
    @(posedge clk);
    @(negedge clk);
    d_req_valid = 1'b0; d_req_we = 1'b0;
    check("rst_in_wait", busy, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_busy",         busy,         32'd0);
    check("rst_d_rsp_valid",  d_rsp_valid,  32'd0);
    check("rst_d_rsp_err",    d_rsp_err,    32'd0);
    check("rst_d_req_ready",  d_req_ready,  32'd0);
    check("rst_if_rsp_valid", if_rsp_valid, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    d_txn(1'b0, 32'd9, 32'd0, rdata, err, lat);
    check("rst_reload_rdata", rdata, 32'h00000011);
    check("rst_reload_err",   err,   32'd0);

    // Zero wait states: back-to-back fetches every 3 cycles, response one edge after accept
    @(negedge clk);
    if_req_valid_0 = 1'b1; if_req_addr_0 = 32'd10; if_rsp_ready_0 = 1'b1;
    ng = 0; rsp_c = -1;
    for (int c = 0; c < 40 && ng < 3; c++) begin
      #1;
      if (if_rsp_valid_0 && rsp_c < 0) begin
        rsp_c = c;
        check("w0_rsp_err", if_rsp_err_0, 32'd0);
      end
      if (if_req_ready_0) begin
        acc_c[ng] = c;
        ng++;
      end
      @(negedge clk);
    end
    if_req_valid_0 = 1'b0;
    check("w0_accept_count", ng, 32'd3);
    if (ng == 3) begin
      check("w0_rsp_latency", rsp_c - acc_c[0], 32'd2);
      check("w0_spacing1",    acc_c[1] - acc_c[0], 32'd3);
      check("w0_spacing2",    acc_c[2] - acc_c[1], 32'd3);
    end
    repeat (4) @(negedge clk);
    check("w0_idle_after", busy_0, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
